fifo_wr_arbiter: RTL

// Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-capable arbiter driving one registered FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_mask,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          ovf_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {ARB, OWNED} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, rr_nx, owner, owner_nx, win, gnt_id_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [NUM_REQ-1:0] act;
  logic can_accept, found, hit, wr_nx;
  logic [FIFO_WIDTH-1:0] data_nx;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction
  assign act = req & req_mask;
  // the in-flight registered write counts against the last free slot
  assign can_accept = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  // candidate: owner while bursting, otherwise first active requester from rr_ptr
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && act[wrap(int'(rr_ptr) + i)]) begin
        found = 1'b1;
        win = wrap(int'(rr_ptr) + i);
      end
    end
    if (state == OWNED) begin
      found = act[owner];
      win = owner;
    end
  end
  assign hit = found && can_accept && rst_n;
  assign gnt = hit ? (NUM_REQ'(1) << win) : '0;
  // next-state: burst accounting, pointer rotation and the registered write stage
  always_comb begin
    state_nx = state;
    rr_nx = rr_ptr;
    owner_nx = owner;
    cnt_nx = cnt;
    wr_nx = hit;
    data_nx = fifo_data_in;
    gnt_id_nx = gnt_id;
    cnt_inc = (state == ARB) ? CW'(1) : cnt + 1'b1;
    if (hit) begin
      data_nx = req_data[win*FIFO_WIDTH +: FIFO_WIDTH];
      gnt_id_nx = win;
      if (cnt_inc == CW'(BURST_LEN)) begin
        state_nx = ARB;
        cnt_nx = '0;
        rr_nx = wrap(int'(win) + 1);
      end else begin
        state_nx = OWNED;
        owner_nx = win;
        cnt_nx = cnt_inc;
      end
    end else if (state == OWNED && !act[owner]) begin
      state_nx = ARB;
      cnt_nx = '0;
      rr_nx = wrap(int'(owner) + 1);
    end
  end
  // state and output registers; overflow error is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data_in <= '0;
      gnt_id <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_nx;
      rr_ptr <= rr_nx;
      owner <= owner_nx;
      cnt <= cnt_nx;
      fifo_wr_en <= wr_nx;
      fifo_data_in <= data_nx;
      gnt_id <= gnt_id_nx;
      ovf_err <= ovf_err | (fifo_overflow & fifo_wr_en);
    end
  end
endmodule
